// File: rtl/axi4lite_pkg.sv
// Shared types and address-range helper for the AXI4-Lite register-file slave.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WR_ACCEPT,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Address is legal when it lies inside the register window and, if alignment
  // checking is on, has no sub-word offset.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] limit,
                                         input logic [63:0] align_mask,
                                         input logic        check_align);
    return (addr < limit) && (!check_align || ((addr & align_mask) == 64'd0));
  endfunction

endpackage

// File: rtl/axi4lite_regfile_slave_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register-file slave.
interface axi4lite_regfile_slave_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);
  logic                          AW_VALID;
  logic                          AW_READY;
  logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR;
  logic                          W_VALID;
  logic                          W_READY;
  logic [AXI_DATA_WIDTH-1:0]     W_DATA;
  logic [AXI_DATA_WIDTH/8-1:0]   W_STRB;
  logic                          B_VALID;
  logic                          B_READY;
  logic [1:0]                    B_RESP;
  logic                          AR_VALID;
  logic                          AR_READY;
  logic [AXI_ADDR_WIDTH-1:0]     AR_ADDR;
  logic                          R_VALID;
  logic                          R_READY;
  logic [AXI_DATA_WIDTH-1:0]     R_DATA;
  logic [1:0]                    R_RESP;

  modport slave (
    input  AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY,
           AR_VALID, AR_ADDR, R_READY,
    output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );

  modport master (
    output AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY,
           AR_VALID, AR_ADDR, R_READY,
    input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );
endinterface

// File: rtl/axi4lite_regfile_core.sv
// Register array with a byte-strobed write port and a registered read port.
module axi4lite_regfile_core #(
  parameter int                  DW          = 32,
  parameter int                  NUM_REGS    = 16,
  parameter logic [DW-1:0]       RESET_VALUE = '0,
  localparam int                 STRB_W      = DW / 8,
  localparam int                 IDX_W       = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DW-1:0]     wr_data_i,
  input  logic [STRB_W-1:0] wr_strb_i,
  input  logic              rd_en_i,
  input  logic              rd_ok_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DW-1:0]     rd_data_o
);

  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] rd_data_q;

  // Read capture samples the pre-edge contents, so a same-edge write is not seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb_i[b]) begin
            regs_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
          end
        end
      end
      if (rd_en_i) begin
        rd_data_q <= rd_ok_i ? regs_q[rd_idx_i] : '0;
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave over a register file; independent read and write FSMs.
// Build option AXI4LITE_ALIGN_CHECK_EN: treat sub-word-unaligned addresses as out of range.
//
// state     | meaning
// WR_ACCEPT | collecting AW and W in any order
// WR_COMMIT | one cycle: strobed write (or SLVERR), clear held flags
// WR_RESP   | B_VALID high until B_READY
// RD_IDLE   | AR_READY high, read data captured on handshake
// RD_DATA   | R_VALID high until R_READY
module axi4lite_regfile_slave
  import axi4lite_pkg::*;
#(
  parameter int                          AXI_ADDR_WIDTH = 32,
  parameter int                          AXI_DATA_WIDTH = 32,
  parameter int                          NUM_REGS       = 16,
  parameter logic [AXI_DATA_WIDTH-1:0]   RESET_VALUE    = '0
) (
  input  logic                     A_CLK,
  input  logic                     A_RST,
  axi4lite_regfile_slave_if.slave  s_axi
);

  localparam int          STRB_W     = AXI_DATA_WIDTH / 8;
  localparam int          ADDR_LSB   = $clog2(STRB_W);
  localparam int          IDX_W      = $clog2(NUM_REGS);
  localparam logic [63:0] REG_LIMIT  = 64'(NUM_REGS) * 64'(STRB_W);
  localparam logic [63:0] ALIGN_MASK = (64'd1 << ADDR_LSB) - 64'd1;
`ifdef AXI4LITE_ALIGN_CHECK_EN
  localparam logic        ALIGN_CHECK = 1'b1;
`else
  localparam logic        ALIGN_CHECK = 1'b0;
`endif

  wr_state_t                  wr_state_q, wr_state_d;
  logic                       aw_held_q, aw_held_d;
  logic                       w_held_q, w_held_d;
  logic [AXI_ADDR_WIDTH-1:0]  aw_addr_q, aw_addr_d;
  logic [AXI_DATA_WIDTH-1:0]  w_data_q, w_data_d;
  logic [STRB_W-1:0]          w_strb_q, w_strb_d;
  resp_t                      bresp_q, bresp_d;
  logic                       aw_ready, w_ready, aw_hs, w_hs, wr_ok, wr_en;

  rd_state_t                  rd_state_q, rd_state_d;
  resp_t                      rresp_q, rresp_d;
  logic                       ar_ready, ar_hs, rd_ok;
  logic [AXI_DATA_WIDTH-1:0]  rd_data;

  // Every handshake signal is forced low in the reset cycle.
  assign aw_ready = !A_RST && (wr_state_q == WR_ACCEPT) && !aw_held_q;
  assign w_ready  = !A_RST && (wr_state_q == WR_ACCEPT) && !w_held_q;
  assign ar_ready = !A_RST && (rd_state_q == RD_IDLE);
  assign aw_hs    = s_axi.AW_VALID && aw_ready;
  assign w_hs     = s_axi.W_VALID && w_ready;
  assign ar_hs    = s_axi.AR_VALID && ar_ready;

  assign wr_ok = addr_in_range(64'(aw_addr_q), REG_LIMIT, ALIGN_MASK, ALIGN_CHECK);
  assign rd_ok = addr_in_range(64'(s_axi.AR_ADDR), REG_LIMIT, ALIGN_MASK, ALIGN_CHECK);

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bresp_d    = bresp_q;
    wr_en      = 1'b0;
    unique case (wr_state_q)
      WR_ACCEPT: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_axi.AW_ADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = s_axi.W_DATA;
          w_strb_d = s_axi.W_STRB;
        end
        if (aw_held_d && w_held_d) begin
          wr_state_d = WR_COMMIT;
        end
      end
      WR_COMMIT: begin
        wr_en      = wr_ok;
        bresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        if (s_axi.B_READY) begin
          wr_state_d = WR_ACCEPT;
        end
      end
      default: wr_state_d = WR_ACCEPT;
    endcase
  end

  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      wr_state_q <= WR_ACCEPT;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bresp_q    <= bresp_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_DATA;
          rresp_d    = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      RD_DATA: begin
        if (s_axi.R_READY) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      rd_state_q <= RD_IDLE;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rresp_q    <= rresp_d;
    end
  end

  axi4lite_regfile_core #(
    .DW          (AXI_DATA_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .RESET_VALUE (RESET_VALUE)
  ) u_core (
    .clk_i     (A_CLK),
    .rst_i     (A_RST),
    .wr_en_i   (wr_en),
    .wr_idx_i  (aw_addr_q[ADDR_LSB +: IDX_W]),
    .wr_data_i (w_data_q),
    .wr_strb_i (w_strb_q),
    .rd_en_i   (ar_hs),
    .rd_ok_i   (rd_ok),
    .rd_idx_i  (s_axi.AR_ADDR[ADDR_LSB +: IDX_W]),
    .rd_data_o (rd_data)
  );

  assign s_axi.AW_READY = aw_ready;
  assign s_axi.W_READY  = w_ready;
  assign s_axi.AR_READY = ar_ready;
  assign s_axi.B_VALID  = !A_RST && (wr_state_q == WR_RESP);
  assign s_axi.B_RESP   = A_RST ? 2'b00 : bresp_q;
  assign s_axi.R_VALID  = !A_RST && (rd_state_q == RD_DATA);
  assign s_axi.R_RESP   = A_RST ? 2'b00 : rresp_q;
  assign s_axi.R_DATA   = A_RST ? '0 : rd_data;

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Directed self-checking bench for axi4lite_regfile_slave (16 x 32-bit registers).
module tb_axi4lite_regfile_slave;

  localparam logic [31:0] RV    = 32'hC0DE_0001;
  localparam int          BOUND = 20;

  logic A_CLK = 1'b0;
  logic A_RST = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 A_CLK = ~A_CLK;

  axi4lite_regfile_slave_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

  axi4lite_regfile_slave #(
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (32),
    .NUM_REGS       (16),
    .RESET_VALUE    (RV)
  ) dut (
    .A_CLK (A_CLK),
    .A_RST (A_RST),
    .s_axi (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus helpers: start and end just after a rising edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_hs, w_hs, got;
    int n;
    aw_done = 0; w_done = 0; got = 0; n = 0; lat = 0; resp = 2'b11;
    bus.AW_VALID = 1'b1; bus.AW_ADDR = addr;
    bus.W_VALID  = 1'b1; bus.W_DATA  = data; bus.W_STRB = strb;
    while (!(aw_done && w_done) && n < BOUND) begin
      @(negedge A_CLK);
      aw_hs = bus.AW_VALID && bus.AW_READY;
      w_hs  = bus.W_VALID && bus.W_READY;
      @(posedge A_CLK); #1;
      if (aw_hs) begin aw_done = 1; bus.AW_VALID = 1'b0; end
      if (w_hs)  begin w_done  = 1; bus.W_VALID  = 1'b0; end
      n++;
    end
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    if (!(aw_done && w_done)) begin
      n_cmp++; n_err++;
      $display("FAIL wr_handshake_timeout addr=%h got aw=%0d w=%0d need both", addr, aw_done, w_done);
      return;
    end
    bus.B_READY = 1'b1;
    n = 0;
    while (!got && n < BOUND) begin
      @(negedge A_CLK);
      lat++;
      if (bus.B_VALID) begin got = 1; resp = bus.B_RESP; end
      n++;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL b_timeout addr=%h got no B_VALID need B_VALID", addr);
    end
    @(posedge A_CLK); #1;
    bus.B_READY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    bit done, hs, got;
    int n;
    done = 0; got = 0; n = 0; lat = 0; data = 32'hx; resp = 2'b11;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = addr;
    while (!done && n < BOUND) begin
      @(negedge A_CLK);
      hs = bus.AR_VALID && bus.AR_READY;
      @(posedge A_CLK); #1;
      if (hs) begin done = 1; bus.AR_VALID = 1'b0; end
      n++;
    end
    bus.AR_VALID = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL ar_handshake_timeout addr=%h got no AR_READY need AR_READY", addr);
      return;
    end
    bus.R_READY = 1'b1;
    n = 0;
    while (!got && n < BOUND) begin
      @(negedge A_CLK);
      lat++;
      if (bus.R_VALID) begin got = 1; data = bus.R_DATA; resp = bus.R_RESP; end
      n++;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL r_timeout addr=%h got no R_VALID need R_VALID", addr);
    end
    @(posedge A_CLK); #1;
    bus.R_READY = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int lat;
    A_RST = 1'b1;
    @(posedge A_CLK); #1;
    @(posedge A_CLK); #1;
    @(negedge A_CLK);
    n_cmp++;
    if ({bus.AW_READY, bus.W_READY, bus.AR_READY, bus.B_VALID, bus.R_VALID} !== 5'b0) begin
      n_err++; $display("FAIL reset_ready_valid got %b need 00000",
        {bus.AW_READY, bus.W_READY, bus.AR_READY, bus.B_VALID, bus.R_VALID});
    end
    n_cmp++;
    if ({bus.B_RESP, bus.R_RESP, bus.R_DATA} !== 36'h0) begin
      n_err++; $display("FAIL reset_payload got %h need 0", {bus.B_RESP, bus.R_RESP, bus.R_DATA});
    end
    @(posedge A_CLK); #1;
    A_RST = 1'b0;
    @(negedge A_CLK);
    n_cmp++;
    if ({bus.AW_READY, bus.W_READY, bus.AR_READY} !== 3'b111) begin
      n_err++; $display("FAIL idle_ready got %b need 111", {bus.AW_READY, bus.W_READY, bus.AR_READY});
    end
    @(posedge A_CLK); #1;
    axi_read(32'h00, d, r, lat);
    n_cmp++;
    if (d !== RV || r !== 2'b00) begin n_err++; $display("FAIL reset_reg0 got %h/%b need %h/00", d, r, RV); end
    axi_read(32'h3C, d, r, lat);
    n_cmp++;
    if (d !== RV || r !== 2'b00) begin n_err++; $display("FAIL reset_reg15 got %h/%b need %h/00", d, r, RV); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, r, lat);
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL wr1_bresp got %b need 00", r); end
    n_cmp++;
    if (lat !== 2) begin n_err++; $display("FAIL wr1_latency got %0d need 2", lat); end
    axi_read(32'h04, d, r, lat);
    n_cmp++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
      n_err++; $display("FAIL rd1_data got %h/%b need deadbeef/00", d, r);
    end
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL rd1_latency got %0d need 1", lat); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; int lat;
    bus.W_VALID = 1'b1; bus.W_DATA = 32'h0000_AA00; bus.W_STRB = 4'b0010;
    @(negedge A_CLK);
    n_cmp++;
    if (bus.W_READY !== 1'b1) begin n_err++; $display("FAIL early_w_ready got %b need 1", bus.W_READY); end
    @(posedge A_CLK); #1;
    bus.W_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge A_CLK);
      n_cmp++;
      if ({bus.AW_READY, bus.W_READY, bus.B_VALID} !== 3'b100) begin
        n_err++; $display("FAIL w_held_wait%0d aw/w/b got %b need 100", i,
          {bus.AW_READY, bus.W_READY, bus.B_VALID});
      end
      @(posedge A_CLK); #1;
    end
    bus.AW_VALID = 1'b1; bus.AW_ADDR = 32'h04;
    @(posedge A_CLK); #1;
    bus.AW_VALID = 1'b0;
    bus.B_READY  = 1'b1;
    @(negedge A_CLK);
    n_cmp++;
    if (bus.B_VALID !== 1'b0) begin n_err++; $display("FAIL late_aw_commit_bvalid got %b need 0", bus.B_VALID); end
    @(negedge A_CLK);
    n_cmp++;
    if (bus.B_VALID !== 1'b1 || bus.B_RESP !== 2'b00) begin
      n_err++; $display("FAIL late_aw_bresp got %b/%b need 1/00", bus.B_VALID, bus.B_RESP);
    end
    @(posedge A_CLK); #1;
    bus.B_READY = 1'b0;
    axi_read(32'h04, d, r, lat);
    n_cmp++;
    if (d !== 32'hDEAD_AAEF) begin n_err++; $display("FAIL strb_merge got %h need deadaaef", d); end
    axi_write(32'h04, 32'hFFFF_FFFF, 4'h0, r, lat);
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL strb0_bresp got %b need 00", r); end
    axi_read(32'h04, d, r, lat);
    n_cmp++;
    if (d !== 32'hDEAD_AAEF) begin n_err++; $display("FAIL strb0_unchanged got %h need deadaaef", d); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, r, lat);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL oor_bresp got %b need 10", r); end
    axi_read(32'h40, d, r, lat);
    n_cmp++;
    if (d !== 32'h0 || r !== 2'b10) begin n_err++; $display("FAIL oor_read got %h/%b need 0/10", d, r); end
    axi_read(32'h00, d, r, lat);
    n_cmp++;
    if (d !== RV) begin n_err++; $display("FAIL oor_alias_reg0 got %h need %h", d, RV); end
    axi_read(32'h04, d, r, lat);
    n_cmp++;
    if (d !== 32'hDEAD_AAEF) begin n_err++; $display("FAIL oor_reg1 got %h need deadaaef", d); end
    axi_write(32'h3C, 32'hCAFE_F00D, 4'hF, r, lat);
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL last_reg_bresp got %b need 00", r); end
    axi_read(32'h3C, d, r, lat);
    n_cmp++;
    if (d !== 32'hCAFE_F00D || r !== 2'b00) begin
      n_err++; $display("FAIL last_reg_read got %h/%b need cafef00d/00", d, r);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] r; int lat;
    bus.AW_VALID = 1'b1; bus.AW_ADDR = 32'h0C;
    bus.W_VALID  = 1'b1; bus.W_DATA  = 32'h55AA_55AA; bus.W_STRB = 4'hF;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = 32'h04;
    @(posedge A_CLK); #1;
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    bus.AR_ADDR  = 32'h38;
    @(posedge A_CLK); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge A_CLK);
      n_cmp++;
      if ({bus.B_VALID, bus.B_RESP, bus.R_VALID, bus.R_RESP, bus.AR_READY} !== 7'b1_00_1_00_0
          || bus.R_DATA !== 32'hDEAD_AAEF) begin
        n_err++; $display("FAIL stall%0d bv/br/rv/rr/arr got %b data %h need 1001000 deadaaef", i,
          {bus.B_VALID, bus.B_RESP, bus.R_VALID, bus.R_RESP, bus.AR_READY}, bus.R_DATA);
      end
      @(posedge A_CLK); #1;
    end
    bus.R_READY = 1'b1;
    @(posedge A_CLK); #1;
    bus.R_READY = 1'b0;
    @(negedge A_CLK);
    n_cmp++;
    if (bus.AR_READY !== 1'b1 || bus.R_VALID !== 1'b0) begin
      n_err++; $display("FAIL after_r_hs arr/rv got %b%b need 10", bus.AR_READY, bus.R_VALID);
    end
    @(posedge A_CLK); #1;
    bus.AR_VALID = 1'b0;
    @(negedge A_CLK);
    n_cmp++;
    if (bus.R_VALID !== 1'b1 || bus.R_DATA !== RV || bus.B_VALID !== 1'b1) begin
      n_err++; $display("FAIL second_read rv/data/bv got %b/%h/%b need 1/%h/1",
        bus.R_VALID, bus.R_DATA, bus.B_VALID, RV);
    end
    bus.R_READY = 1'b1; bus.B_READY = 1'b1;
    @(posedge A_CLK); #1;
    bus.R_READY = 1'b0; bus.B_READY = 1'b0;
    axi_read(32'h0C, d, r, lat);
    n_cmp++;
    if (d !== 32'h55AA_55AA) begin n_err++; $display("FAIL stalled_write_data got %h need 55aa55aa", d); end
  endtask

  task automatic test_read_during_commit();
    logic [31:0] d; logic [1:0] r; int lat;
    bus.AW_VALID = 1'b1; bus.AW_ADDR = 32'h08;
    bus.W_VALID  = 1'b1; bus.W_DATA  = 32'h1234_5678; bus.W_STRB = 4'hF;
    @(posedge A_CLK); #1;
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = 32'h08;
    @(posedge A_CLK); #1;
    bus.AR_VALID = 1'b0;
    @(negedge A_CLK);
    n_cmp++;
    if (bus.R_VALID !== 1'b1 || bus.R_DATA !== RV || bus.B_VALID !== 1'b1) begin
      n_err++; $display("FAIL collide_old rv/data/bv got %b/%h/%b need 1/%h/1",
        bus.R_VALID, bus.R_DATA, bus.B_VALID, RV);
    end
    bus.R_READY = 1'b1; bus.B_READY = 1'b1;
    @(posedge A_CLK); #1;
    bus.R_READY = 1'b0; bus.B_READY = 1'b0;
    axi_read(32'h08, d, r, lat);
    n_cmp++;
    if (d !== 32'h1234_5678) begin n_err++; $display("FAIL collide_new got %h need 12345678", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int lat;
    bus.AW_VALID = 1'b1; bus.AW_ADDR = 32'h10;
    bus.W_VALID  = 1'b1; bus.W_DATA  = 32'hFFFF_0000; bus.W_STRB = 4'hF;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = 32'h04;
    @(posedge A_CLK); #1;
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0; bus.AR_VALID = 1'b0;
    @(posedge A_CLK); #1;
    @(negedge A_CLK);
    n_cmp++;
    if (bus.B_VALID !== 1'b1 || bus.R_VALID !== 1'b1) begin
      n_err++; $display("FAIL pre_reset bv/rv got %b%b need 11", bus.B_VALID, bus.R_VALID);
    end
    A_RST = 1'b1;
    #1;
    n_cmp++;
    if ({bus.AW_READY, bus.W_READY, bus.AR_READY, bus.B_VALID, bus.R_VALID} !== 5'b0
        || {bus.B_RESP, bus.R_RESP, bus.R_DATA} !== 36'h0) begin
      n_err++; $display("FAIL mid_reset_outputs got %b %h need 0",
        {bus.AW_READY, bus.W_READY, bus.AR_READY, bus.B_VALID, bus.R_VALID},
        {bus.B_RESP, bus.R_RESP, bus.R_DATA});
    end
    @(posedge A_CLK); #1;
    A_RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge A_CLK);
      n_cmp++;
      if ({bus.B_VALID, bus.R_VALID, bus.AW_READY, bus.AR_READY} !== 4'b0011) begin
        n_err++; $display("FAIL post_reset%0d bv/rv/awr/arr got %b need 0011", i,
          {bus.B_VALID, bus.R_VALID, bus.AW_READY, bus.AR_READY});
      end
      @(posedge A_CLK); #1;
    end
    axi_read(32'h10, d, r, lat);
    n_cmp++;
    if (d !== RV) begin n_err++; $display("FAIL reset_restores_reg4 got %h need %h", d, RV); end
    axi_read(32'h04, d, r, lat);
    n_cmp++;
    if (d !== RV) begin n_err++; $display("FAIL reset_restores_reg1 got %h need %h", d, RV); end
  endtask

  task automatic test_unaligned();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(32'h06, 32'h1122_3344, 4'hF, r, lat);
`ifdef AXI4LITE_ALIGN_CHECK_EN
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL unaligned_bresp got %b need 10", r); end
    axi_read(32'h06, d, r, lat);
    n_cmp++;
    if (d !== 32'h0 || r !== 2'b10) begin n_err++; $display("FAIL unaligned_read got %h/%b need 0/10", d, r); end
    axi_read(32'h04, d, r, lat);
    n_cmp++;
    if (d !== RV) begin n_err++; $display("FAIL unaligned_no_write got %h need %h", d, RV); end
`else
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL unaligned_bresp got %b need 00", r); end
    axi_read(32'h06, d, r, lat);
    n_cmp++;
    if (d !== 32'h1122_3344 || r !== 2'b00) begin
      n_err++; $display("FAIL unaligned_read got %h/%b need 11223344/00", d, r);
    end
    axi_read(32'h04, d, r, lat);
    n_cmp++;
    if (d !== 32'h1122_3344) begin n_err++; $display("FAIL unaligned_containing got %h need 11223344", d); end
`endif
  endtask

  initial begin
    bus.AW_VALID = 1'b0; bus.AW_ADDR = '0;
    bus.W_VALID  = 1'b0; bus.W_DATA  = '0; bus.W_STRB = '0;
    bus.B_READY  = 1'b0;
    bus.AR_VALID = 1'b0; bus.AR_ADDR = '0;
    bus.R_READY  = 1'b0;
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_read_during_commit();
    test_reset_mid();
    test_unaligned();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
